// File: rtl/dmem_pkg.sv
// dmem_pkg: size encodings, controller states and byte-enable helper shared by the data-memory front-end
package dmem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  typedef enum logic {IDLE, RESP} state_t;
  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] addr_lo);
    return size == SZ_BYTE ? 4'b0001 << addr_lo :
           size == SZ_HALF ? 4'b0011 << {addr_lo[1], 1'b0} :
           size == SZ_WORD ? 4'b1111 : 4'b0000;
  endfunction
endpackage

// File: rtl/dmem_ld_align.sv
// dmem_ld_align: picks byte/half/word out of a RAM word (rd_data, addr_lo, size, uns) and sign/zero-extends it into rdata
module dmem_ld_align
  import dmem_pkg::*;
(
  input  logic [31:0] rd_data,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] rdata
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rd_data[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? rd_data[31:16] : rd_data[15:0];
    rdata = size == SZ_BYTE ? {{24{b[7] & ~uns}}, b} :
            size == SZ_HALF ? {{16{h[15] & ~uns}}, h} : rd_data;
  end
endmodule

// File: rtl/dmem_ram_ctrl.sv
// dmem_ram_ctrl: load/store front-end for an 8Kx32 RAM; req_* handshake in, rsp_* handshake out, ram_* to the RAM, err_cnt counts errored requests
module dmem_ram_ctrl
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          RAM_AW    = 13,
  parameter int          ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [31:0]          req_addr,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic [RAM_AW-1:0]    ram_addr,
  output logic [31:0]          ram_wr_data,
  output logic                 ram_wr_en,
  output logic [3:0]           ram_wr_byte_en,
  input  logic [31:0]          ram_rd_data,
  output logic [ERR_CNT_W-1:0] err_cnt
);
  state_t            state, state_d;
  logic [RAM_AW-1:0] addr_q;
  logic [1:0]        lo_q, size_q;
  logic              uns_q, we_q, err_q, acc, err;
  logic [31:0]       ld_data;
  // gating with rst keeps a request from reaching the RAM while reset is held
  assign req_ready = rst && (state == IDLE || rsp_ready);
  assign acc = req_valid && req_ready;
  assign err = req_size == 2'd3 || (req_size == SZ_HALF && req_addr[0]) ||
               (req_size == SZ_WORD && req_addr[1:0] != 2'b00) ||
               req_addr[31:RAM_AW+2] != BASE_ADDR[31:RAM_AW+2];
  // holding addr_q while stalled makes the RAM re-read the same word, so load data stays stable uncaptured
  assign ram_addr = acc ? req_addr[RAM_AW+1:2] : addr_q;
  assign ram_wr_en = acc && req_we && !err;
  assign ram_wr_byte_en = ram_wr_en ? be_gen(req_size, req_addr[1:0]) : 4'b0000;
  assign ram_wr_data = req_size == SZ_BYTE ? {4{req_wdata[7:0]}} :
                       req_size == SZ_HALF ? {2{req_wdata[15:0]}} : req_wdata;
  assign rsp_valid = state == RESP;
  assign rsp_err = rsp_valid && err_q;
  assign rsp_rdata = rsp_valid && !we_q && !err_q ? ld_data : 32'd0;
  dmem_ld_align u_align (
    .rd_data(ram_rd_data),
    .addr_lo(lo_q),
    .size   (size_q),
    .uns    (uns_q),
    .rdata  (ld_data)
  );
  always_comb state_d = acc ? RESP : rsp_ready ? IDLE : state;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      lo_q    <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      err_cnt <= '0;
    end else begin
      state <= state_d;
      if (acc) begin
        addr_q <= req_addr[RAM_AW+1:2];
        lo_q   <= req_addr[1:0];
        size_q <= req_size;
        uns_q  <= req_unsigned;
        we_q   <= req_we;
        err_q  <= err;
      end
      if (acc && err && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
    end
endmodule
